// File: rtl/vga_timing_gen.sv
// 640x480@60Hz raster timing: scan counters, blank and PIPE_DLY-aligned active-low syncs.
// Define FRAME_COUNT_EN to build the 8-bit frame counter; otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIPE_DLY  = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       lineEnd;
  logic       hsRaw, vsRaw;
  logic       hsDly, vsDly;

  assign lineEnd = (hc_q == H_LAST);

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (lineEnd) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hsRaw = !((hc_q >= H_SYNC_START) && (hc_q < H_SYNC_END));
  assign vsRaw = !((vc_q >= V_SYNC_START) && (vc_q < V_SYNC_END));

  // Sync delay matches the latency of the registered colour stage downstream.
  generate
    if (PIPE_DLY == 0) begin : g_noPipe
      assign hsDly = hsRaw;
      assign vsDly = vsRaw;
    end else begin : g_pipe
      logic [PIPE_DLY-1:0] hsPipe_q;
      logic [PIPE_DLY-1:0] vsPipe_q;

      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hsPipe_q <= '1;
          vsPipe_q <= '1;
        end else begin
          hsPipe_q[0] <= hsRaw;
          vsPipe_q[0] <= vsRaw;
          for (int i = 1; i < PIPE_DLY; i++) begin
            hsPipe_q[i] <= hsPipe_q[i-1];
            vsPipe_q[i] <= vsPipe_q[i-1];
          end
        end
      end

      assign hsDly = hsPipe_q[PIPE_DLY-1];
      assign vsDly = vsPipe_q[PIPE_DLY-1];
    end
  endgenerate

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = !reset && (hc_q < H_VIS) && (vc_q < V_VIS);
  assign frame_start = !reset && (hc_q == '0) && (vc_q == '0);
  assign hs          = hsDly | reset;
  assign vs          = vsDly | reset;

`ifdef FRAME_COUNT_EN
  logic [7:0] frameCnt_q, frameCnt_d;
  logic       frameEnd;

  // Advances on the (last,last)->(0,0) wrap so the new count is visible with frame_start.
  assign frameEnd   = lineEnd && (vc_q == V_LAST);
  assign frameCnt_d = frameEnd ? frameCnt_q + 8'd1 : frameCnt_q;

  always_ff @(posedge vga_clk) begin
    if (reset) frameCnt_q <= '0;
    else       frameCnt_q <= frameCnt_d;
  end

  assign frame_cnt = frameCnt_q;
`else
  assign frame_cnt = 8'h00;
`endif

endmodule
